// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: bit-period rounding (common with the receiver),
// frame length and transmitter FSM encodings.
package uart_tx_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Clocks per bit, rounded to nearest so TX and RX pick the same period.
  function automatic int calc_div(input int f, input int baud);
    return (f + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_counter.sv
// Free-running modulo-N counter; ovf pulses on the last count and is used
// as the bit strobe by the UART.
module uart_tx_counter #(
  parameter int N = 69,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  assign ovf = en && (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= ovf ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input. tx is the LSB of a
// registered shift register, so the line only changes on clock edges.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int F    = 8000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = calc_div(F, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: F/BAUD gives fewer than 2 clocks per bit");
  end

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [2:0]            idx;
  logic [TW-1:0]         cnt;
  logic                  tick;
  logic                  accept;

  assign accept = valid && ready;
  assign tx     = shreg[0];

  // Clearing on acceptance aligns every bit boundary to the accept edge.
  uart_tx_counter #(.N(DIV)) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (1'b1),
    .cnt (cnt),
    .ovf (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '1;
      idx   <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else if (accept) begin
      state <= START;
      shreg <= {1'b1, data, 1'b0};
      idx   <= '0;
      ready <= 1'b0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        START: if (tick) begin
          state <= DATA;
          idx   <= '0;
          shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
        end
        DATA: if (tick) begin
          shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
          if (idx == 3'd7) state <= STOP;
          else             idx   <= idx + 3'd1;
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else if (cnt == TW'(DIV - 2)) begin
            // Open the handshake for the final stop cycle so frames can abut.
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a DIV=5 instance for timing scenarios and a
// default-parameter instance looped into a mid-bit sampling receiver model.
module tb_uart_tx;

  localparam int DIV_S = 5;
  localparam int DIV_L = 69;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] s_data, l_data;
  logic       s_valid, l_valid;
  logic       s_ready, s_tx, s_busy;
  logic       l_ready, l_tx, l_busy;

  uart_tx #(.F(10), .BAUD(2)) u_dut (
    .clk(clk), .rst(rst), .data(s_data), .valid(s_valid),
    .ready(s_ready), .tx(s_tx), .busy(s_busy)
  );

  uart_tx u_dut_def (
    .clk(clk), .rst(rst), .data(l_data), .valid(l_valid),
    .ready(l_ready), .tx(l_tx), .busy(l_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] lq[$];

  // Hold valid until ready; record the expected byte and the cycle of its first start-bit level.
  task automatic send_s(input logic [7:0] byte_in);
    int n = 0;
    s_valid = 1'b1;
    s_data  = byte_in;
    while (s_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready ready=%b required 1 within 200 cycles", s_ready);
    end else begin
      sb.push_back('{b: byte_in, acc: cyc + 1});
    end
    @(negedge clk);
  endtask

  task automatic mon_s(output int start_cyc);
    exp_t       e;
    logic [9:0] fr;
    logic       ok;
    int         n = 0;
    start_cyc = -1;
    @(negedge clk);
    while (s_tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    start_cyc = cyc;
    vectors++;
    if (s_tx !== 1'b0 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL mon_start tx=%b queued=%0d required start bit with queued byte", s_tx, sb.size());
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (start_cyc != e.acc) begin
      miscompares++;
      $display("FAIL start_latency start_cycle=%0d required %0d", start_cyc, e.acc);
    end
    fr = {1'b1, e.b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      ok = 1'b1;
      for (int c = 0; c < DIV_S; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (s_tx !== fr[k]) ok = 1'b0;
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL frame_bit byte=%h bit=%0d tx=%b required %b for %0d cycles",
                 e.b, k, s_tx, fr[k], DIV_S);
      end
    end
  endtask

  task automatic test_reset;
    logic ok;
    rst = 1'b0; s_valid = 1'b1; s_data = 8'hA5; l_valid = 1'b0; l_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++; if (s_tx !== 1'b1)    begin miscompares++; $display("FAIL reset_tx tx=%b required 1", s_tx); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready ready=%b required 1", s_ready); end
    vectors++; if (s_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy busy=%b required 0", s_busy); end
    rst = 1'b1; s_valid = 1'b0;
    ok = 1'b1;
    repeat (20) begin @(negedge clk); if (s_tx !== 1'b1 || s_busy !== 1'b0) ok = 1'b0; end
    vectors++; if (!ok) begin miscompares++; $display("FAIL idle_after_reset tx=%b busy=%b required 1/0", s_tx, s_busy); end
  endtask

  task automatic test_single;
    int st, lo = 0, bh = 0;
    @(negedge clk);
    fork
      begin send_s(8'h55); s_valid = 1'b0; end
      mon_s(st);
      repeat (60) begin
        @(negedge clk);
        if (s_ready === 1'b0) lo++;
        if (s_busy === 1'b1) bh++;
      end
    join
    vectors++; if (lo != 49) begin miscompares++; $display("FAIL ready_low_cycles got=%0d required 49", lo); end
    vectors++; if (bh != 50) begin miscompares++; $display("FAIL busy_cycles got=%0d required 50", bh); end
    vectors++;
    if (s_busy !== 1'b0 || s_ready !== 1'b1 || s_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_frame busy=%b ready=%b tx=%b required 0/1/1", s_busy, s_ready, s_tx);
    end
  endtask

  task automatic test_back_to_back;
    int st1, st2, last;
    @(negedge clk);
    fork
      begin send_s(8'hA3); send_s(8'h0F); s_valid = 1'b0; end
      begin mon_s(st1); mon_s(st2); last = cyc; end
    join
    vectors++; if (st2 - st1 != 10 * DIV_S) begin miscompares++; $display("FAIL b2b_gap spacing=%0d required %0d", st2 - st1, 10 * DIV_S); end
    vectors++; if (last - st1 + 1 != 100) begin miscompares++; $display("FAIL b2b_length cycles=%0d required 100", last - st1 + 1); end
    @(negedge clk);
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end busy=%b required 0", s_busy); end
  endtask

  task automatic test_data_stability;
    int st;
    @(negedge clk);
    fork
      begin
        send_s(8'h3C); s_valid = 1'b0;
        repeat (48) begin s_data = 8'($urandom); @(negedge clk); end
      end
      mon_s(st);
    join
  endtask

  task automatic test_reset_mid;
    int st;
    logic ok;
    @(negedge clk);
    send_s(8'h00); s_valid = 1'b0;
    repeat (21) @(negedge clk);
    vectors++; if (s_tx !== 1'b0) begin miscompares++; $display("FAIL pre_reset_tx tx=%b required 0", s_tx); end
    #1 rst = 1'b0;
    #1;
    vectors++; if (s_tx !== 1'b1)    begin miscompares++; $display("FAIL midreset_tx tx=%b required 1", s_tx); end
    vectors++; if (s_busy !== 1'b0)  begin miscompares++; $display("FAIL midreset_busy busy=%b required 0", s_busy); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready ready=%b required 1", s_ready); end
    sb.delete();
    @(negedge clk); rst = 1'b1;
    ok = 1'b1;
    repeat (60) begin @(negedge clk); if (s_tx !== 1'b1 || s_busy !== 1'b0) ok = 1'b0; end
    vectors++; if (!ok) begin miscompares++; $display("FAIL no_resume tx=%b busy=%b required 1/0", s_tx, s_busy); end
    fork
      begin send_s(8'hFF); s_valid = 1'b0; end
      mon_s(st);
    join
  endtask

  task automatic rx_l(output logic [7:0] b, output logic good);
    int n = 0;
    good = 1'b1; b = 8'h00;
    @(negedge clk);
    while (l_tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    if (l_tx !== 1'b0) begin good = 1'b0; return; end
    repeat (DIV_L / 2) @(negedge clk);
    if (l_tx !== 1'b0) good = 1'b0;
    for (int i = 0; i < 8; i++) begin repeat (DIV_L) @(negedge clk); b[i] = l_tx; end
    repeat (DIV_L) @(negedge clk);
    if (l_tx !== 1'b1) good = 1'b0;
  endtask

  task automatic test_loopback;
    logic [7:0] pats [3];
    logic [7:0] got, want;
    logic       good;
    int         bh, n;
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h5A;
    for (int p = 0; p < 3; p++) begin
      bh = 0;
      @(negedge clk);
      fork
        begin
          n = 0;
          l_valid = 1'b1; l_data = pats[p];
          while (l_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
          lq.push_back(pats[p]);
          @(negedge clk); l_valid = 1'b0;
        end
        rx_l(got, good);
        repeat (720) begin @(negedge clk); if (l_busy === 1'b1) bh++; end
      join
      want = lq.pop_front();
      vectors++; if (!good)       begin miscompares++; $display("FAIL loop_framing byte=%h start/stop not seen at mid-bit", want); end
      vectors++; if (got !== want) begin miscompares++; $display("FAIL loop_data got=%h required %h", got, want); end
      vectors++; if (bh != 10 * DIV_L) begin miscompares++; $display("FAIL loop_frame_len busy_cycles=%0d required %0d", bh, 10 * DIV_L); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_data_stability();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
